// File: rtl/seg_scan_pkg.sv
// =============================================================================
// Module  : seg_scan_pkg
// Brief   : Shared constants and state type for the 7-segment anode scanner.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

package seg_scan_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

    localparam logic [NUM_DIGITS-1:0] ANODE_ONEHOT [0:NUM_DIGITS-1] =
        '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SCAN  = 1'b1
    } scan_state_t;

    // Only ever yields a one-cold strobe or all-off, so two digits can never light together.
    function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [1:0] idx, input logic lit);
        return lit ? ANODE_ONEHOT[idx] : ANODE_OFF;
    endfunction

endpackage

`default_nettype wire

// File: rtl/scan_prescaler.sv
// =============================================================================
// Module  : scan_prescaler
// Brief   : Slot prescaler counting 0..REFRESH_DIV-1 while enabled; tick on last count.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module scan_prescaler #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tick_o
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Combinational so the tick is exactly the cycle whose closing edge wraps the count.
    assign tick_o = en_i && (cnt_q == c_last);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/anode_scan_ctrl.sv
// =============================================================================
// Module  : anode_scan_ctrl
// Brief   : 4-digit common-anode scan controller with optional anti-ghost blank
//           window, enabled by macro SEG_SCAN_BLANK_GAP_EN.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module anode_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] digit_en,
    output logic [3:0] anode,
    output logic [1:0] digit_idx,
    output logic       slot_tick
);

    localparam int c_cnt_w = $clog2(REFRESH_DIV);
    localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BLANK_CYCLES - 1);

`ifdef SEG_SCAN_BLANK_GAP_EN
    localparam bit c_blank_en = (BLANK_CYCLES > 0);
`else
    localparam bit c_blank_en = 1'b0;
`endif

    localparam scan_state_t c_rst_state = c_blank_en ? ST_BLANK : ST_SCAN;

    logic [c_cnt_w-1:0] cnt;
    logic               tick;

    logic [1:0]         idx_q, idx_d;
    scan_state_t        state_q, state_d;
    logic [3:0]         anode_q, anode_d;

    scan_prescaler #(
        .REFRESH_DIV (REFRESH_DIV),
        .CNT_W       (c_cnt_w)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en),
        .cnt_o  (cnt),
        .tick_o (tick)
    );

    always_comb begin
        idx_d   = tick ? idx_q + 2'd1 : idx_q;
        state_d = state_q;
        if (!c_blank_en) begin
            state_d = ST_SCAN;
        end else if (tick) begin
            state_d = ST_BLANK;
        end else if (en && (cnt == c_blank_last)) begin
            state_d = ST_SCAN;
        end
        // Built from next-state values so the strobe lines up with the registered index.
        anode_d = anode_for(idx_d, en && digit_en[idx_d] && (state_d == ST_SCAN));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            state_q <= c_rst_state;
            anode_q <= ANODE_OFF;
        end else begin
            idx_q   <= idx_d;
            state_q <= state_d;
            anode_q <= anode_d;
        end
    end

    assign anode     = anode_q;
    assign digit_idx = idx_q;
    assign slot_tick = tick;

endmodule

`default_nettype wire

// File: tb/tb_anode_scan_ctrl.sv
// =============================================================================
// Module  : tb_anode_scan_ctrl
// Brief   : Self-checking bench for anode_scan_ctrl (REFRESH_DIV=4, BLANK_CYCLES=1);
//           expectations follow macro SEG_SCAN_BLANK_GAP_EN.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_anode_scan_ctrl;

    localparam int DIV = 4;
    localparam int BLK = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] digit_en = 4'hF;
    logic [3:0] anode;
    logic [1:0] digit_idx;
    logic       slot_tick;

    always #5 clk = ~clk;

    anode_scan_ctrl #(
        .REFRESH_DIV  (DIV),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .digit_en  (digit_en),
        .anode     (anode),
        .digit_idx (digit_idx),
        .slot_tick (slot_tick)
    );

    // n consecutive cycles with identical inputs and identical expected outputs.
    typedef struct {
        int         n;
        logic       r;
        logic       e;
        logic [3:0] de;
        logic [3:0] an;
        logic [1:0] idx;
        logic       tk;
        bit         chk;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic add(input int n, input logic r, input logic e, input logic [3:0] de,
                       input logic [3:0] an, input logic [1:0] idx, input logic tk,
                       input bit chk = 1'b1);
        vec_t v;
        v.n = n; v.r = r; v.e = e; v.de = de;
        v.an = an; v.idx = idx; v.tk = tk; v.chk = chk;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    logic [1:0] p_idx;
    logic       p_tk;
    logic       p_rst;
    logic [1:0] e_idx;
    logic       legal;

    initial begin
        add(1, 1, 0, 4'hF, 4'hF, 2'd0, 0, 1'b0);
        add(2, 1, 0, 4'hF, 4'b1111, 2'd0, 0);
`ifdef SEG_SCAN_BLANK_GAP_EN
        add(1, 0, 1, 4'hF, 4'b1111, 2'd0, 0);
        add(2, 0, 1, 4'hF, 4'b1110, 2'd0, 0);
        add(1, 0, 1, 4'hF, 4'b1110, 2'd0, 1);
        add(1, 0, 1, 4'hF, 4'b1111, 2'd1, 0);
        add(2, 0, 1, 4'hF, 4'b1101, 2'd1, 0);
        add(1, 0, 1, 4'hF, 4'b1101, 2'd1, 1);
        add(1, 0, 1, 4'hF, 4'b1111, 2'd2, 0);
        add(2, 0, 1, 4'hF, 4'b1011, 2'd2, 0);
        add(1, 0, 1, 4'hF, 4'b1011, 2'd2, 1);
        add(1, 0, 1, 4'hF, 4'b1111, 2'd3, 0);
        add(2, 0, 1, 4'hF, 4'b0111, 2'd3, 0);
        add(1, 0, 1, 4'hF, 4'b0111, 2'd3, 1);
        add(1, 0, 1, 4'hF, 4'b1111, 2'd0, 0);
        add(2, 0, 1, 4'hF, 4'b1110, 2'd0, 0);
        add(1, 0, 1, 4'hF, 4'b1110, 2'd0, 1);
        add(3, 0, 0, 4'hF, 4'b1111, 2'd1, 0);
        add(1, 0, 1, 4'hF, 4'b1111, 2'd1, 0);
        add(1, 0, 1, 4'hF, 4'b1101, 2'd1, 0);
        add(1, 0, 0, 4'hF, 4'b1101, 2'd1, 0);
        add(1, 0, 1, 4'hF, 4'b1111, 2'd1, 0);
        add(1, 0, 1, 4'hF, 4'b1101, 2'd1, 1);
        add(1, 1, 1, 4'hF, 4'b1111, 2'd2, 0);
        add(1, 0, 1, 4'hF, 4'b1111, 2'd0, 0);
        add(1, 0, 1, 4'hF, 4'b1110, 2'd0, 0);
`else
        // Full scan from reset.
        add(1, 0, 1, 4'hF, 4'b1111, 2'd0, 0);
        add(2, 0, 1, 4'hF, 4'b1110, 2'd0, 0);
        add(1, 0, 1, 4'hF, 4'b1110, 2'd0, 1);
        add(3, 0, 1, 4'hF, 4'b1101, 2'd1, 0);
        add(1, 0, 1, 4'hF, 4'b1101, 2'd1, 1);
        add(3, 0, 1, 4'hF, 4'b1011, 2'd2, 0);
        add(1, 0, 1, 4'hF, 4'b1011, 2'd2, 1);
        add(3, 0, 1, 4'hF, 4'b0111, 2'd3, 0);
        add(1, 0, 1, 4'hF, 4'b0111, 2'd3, 1);
        add(3, 0, 1, 4'hF, 4'b1110, 2'd0, 0);
        add(1, 0, 1, 4'hF, 4'b1110, 2'd0, 1);
        add(3, 0, 1, 4'hF, 4'b1101, 2'd1, 0);
        add(1, 0, 1, 4'hF, 4'b1101, 2'd1, 1);
        // Freeze in digit 2 at cnt=1 for 5 cycles, then resume.
        add(1, 0, 1, 4'hF, 4'b1011, 2'd2, 0);
        add(1, 0, 0, 4'hF, 4'b1011, 2'd2, 0);
        add(4, 0, 0, 4'hF, 4'b1111, 2'd2, 0);
        add(1, 0, 1, 4'hF, 4'b1111, 2'd2, 0);
        add(1, 0, 1, 4'hF, 4'b1011, 2'd2, 0);
        add(1, 0, 1, 4'hF, 4'b1011, 2'd2, 1);
        add(3, 0, 1, 4'hF, 4'b0111, 2'd3, 0);
        // en dropped on the last count: no tick, no advance.
        add(1, 0, 0, 4'hF, 4'b0111, 2'd3, 0);
        add(1, 0, 1, 4'hF, 4'b1111, 2'd3, 1);
        // Digit mask 1010.
        add(1, 0, 1, 4'hA, 4'b1110, 2'd0, 0);
        add(2, 0, 1, 4'hA, 4'b1111, 2'd0, 0);
        add(1, 0, 1, 4'hA, 4'b1111, 2'd0, 1);
        add(3, 0, 1, 4'hA, 4'b1101, 2'd1, 0);
        add(1, 0, 1, 4'hA, 4'b1101, 2'd1, 1);
        add(3, 0, 1, 4'hA, 4'b1111, 2'd2, 0);
        add(1, 0, 1, 4'hA, 4'b1111, 2'd2, 1);
        add(3, 0, 1, 4'hA, 4'b0111, 2'd3, 0);
        add(1, 0, 1, 4'hA, 4'b0111, 2'd3, 1);
        add(3, 0, 1, 4'hA, 4'b1111, 2'd0, 0);
        add(1, 0, 1, 4'hA, 4'b1111, 2'd0, 1);
        add(3, 0, 1, 4'hA, 4'b1101, 2'd1, 0);
        add(1, 0, 1, 4'hA, 4'b1101, 2'd1, 1);
        add(3, 0, 1, 4'hA, 4'b1111, 2'd2, 0);
        add(1, 0, 1, 4'hA, 4'b1111, 2'd2, 1);
        add(2, 0, 1, 4'hA, 4'b0111, 2'd3, 0);
        // Reset mid-slot at digit 3, cnt=2.
        add(1, 1, 1, 4'hA, 4'b0111, 2'd3, 0);
        add(1, 0, 1, 4'hF, 4'b1111, 2'd0, 0);
        add(2, 0, 1, 4'hF, 4'b1110, 2'd0, 0);
        add(1, 0, 1, 4'hF, 4'b1110, 2'd0, 1);
        // All digits masked: ticks continue, anodes dark.
        add(1, 0, 1, 4'h0, 4'b1101, 2'd1, 0);
        add(2, 0, 1, 4'h0, 4'b1111, 2'd1, 0);
        add(1, 0, 1, 4'h0, 4'b1111, 2'd1, 1);
        add(1, 0, 1, 4'h0, 4'b1111, 2'd2, 0);
`endif

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                rst      = tbl[i].r;
                en       = tbl[i].e;
                digit_en = tbl[i].de;
                @(negedge clk);
                if (tbl[i].chk) begin
                    check($sformatf("vec%0d.%0d anode", i, k), anode, tbl[i].an);
                    check($sformatf("vec%0d.%0d digit_idx", i, k), {2'b00, digit_idx}, {2'b00, tbl[i].idx});
                    check($sformatf("vec%0d.%0d slot_tick", i, k), {3'b000, slot_tick}, {3'b000, tbl[i].tk});
                end
                @(posedge clk);
                #1;
            end
        end

        // Random soak: anode legality and index-advance rule.
        p_idx = 2'd0;
        p_tk  = 1'b0;
        p_rst = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            rst      = ($urandom_range(0, 199) == 0);
            en       = ($urandom_range(0, 9) != 0);
            digit_en = 4'($urandom_range(0, 15));
            @(negedge clk);
            if (c > 0) begin
                legal = (anode == 4'b1111) || (anode == ~(4'b0001 << digit_idx));
                n_checks++;
                if (!legal) begin
                    n_err++;
                    $display("FAIL rnd%0d anode legal: got %b with digit_idx %0d", c, anode, digit_idx);
                end
                e_idx = p_rst ? 2'd0 : (p_tk ? p_idx + 2'd1 : p_idx);
                check($sformatf("rnd%0d digit_idx", c), {2'b00, digit_idx}, {2'b00, e_idx});
            end
            p_idx = digit_idx;
            p_tk  = slot_tick;
            p_rst = rst;
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
